jk_cmd_sequencer: RTL and testbench

Command sequencer that sits directly upstream of the two-state JK flip-flop FSM and drives its `j`/`k` inputs. It accepts set/reset/toggle/hold commands with a repeat count over a valid/ready handshake and buffers them in a small FIFO. It issues each command as a single-cycle `j`/`k` pulse, then checks the FSM's `q` feedback against an internal expected-state model. Any mismatch raises a sticky error flag.

---
 rtl/jk_seq_pkg.sv | 34 +++
 rtl/jk_cmd_fifo.sv | 50 +++++
 rtl/jk_cmd_sequencer.sv | 130 +++++++++++++
 tb/tb_jk_cmd_sequencer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/jk_seq_pkg.sv
// Shared types for the JK command sequencer.
// Op encodings, FSM states and the expected-state helper.
package jk_seq_pkg;

    typedef enum logic [1:0] {
        OP_HOLD   = 2'b00,
        OP_SET    = 2'b01,
        OP_RESET  = 2'b10,
        OP_TOGGLE = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        WAIT  = 2'd2,
        CHECK = 2'd3
    } state_e;

    function automatic logic next_exp(
        input op_e  op,
        input logic cur
    );
        logic nxt;
        nxt = cur;
        unique case (1'b1)
            (op == OP_SET):    nxt = 1'b1;
            (op == OP_RESET):  nxt = 1'b0;
            (op == OP_TOGGLE): nxt = ~cur;
            default:           nxt = cur;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/jk_cmd_fifo.sv
// Command FIFO for the JK sequencer.
// Wrap-bit pointers, first-word-fall-through read.
module jk_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 6
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [W-1:0]                 wdata,
    input  logic                         pop,
    output logic [W-1:0]                 rdata,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         full,
    output logic                         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign level   = LW'(wr_ptr - rd_ptr);
    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    // Pointer update; a flush on reset empties the queue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents are don't-care until pushed.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/jk_cmd_sequencer.sv
// Drives j/k of a JK FSM from queued commands.
// Checks q feedback against an expected-state model.
module jk_cmd_sequencer
    import jk_seq_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 4,
    parameter int FB_LAT = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [1:0]                   cmd_op,
    input  logic [CNT_W-1:0]             cmd_rep,
    output logic                         j,
    output logic                         k,
    input  logic                         q_fb,
    input  logic                         err_clr,
    output logic                         err,
    output logic                         busy,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int WW = (FB_LAT > 1) ? $clog2(FB_LAT) : 1;

    state_e             state;
    state_e             nstate;
    op_e                op_r;
    logic [CNT_W-1:0]   rem_r;
    logic [WW-1:0]      wcnt;
    logic               exp_r;
    logic [CNT_W+1:0]   head;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic               dec_rem;
    logic               mismatch;
    logic [1:0]         nxt_op;

    assign cmd_ready = !full;
    assign push      = cmd_valid && cmd_ready;
    assign busy      = (state != IDLE) || !empty;

    jk_cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (CNT_W + 2)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata ({cmd_rep, cmd_op}),
        .pop   (pop),
        .rdata (head),
        .level (level),
        .full  (full),
        .empty (empty)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nstate;
    end

    // Next state, pop/repeat decisions and feedback compare.
    always_comb begin
        nstate   = state;
        pop      = 1'b0;
        dec_rem  = 1'b0;
        mismatch = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    pop    = 1'b1;
                    nstate = DRIVE;
                end
            end
            DRIVE: nstate = WAIT;
            WAIT: begin
                if (wcnt == '0) nstate = CHECK;
            end
            CHECK: begin
                mismatch = (q_fb != exp_r);
                if (rem_r != '0) begin
                    dec_rem = 1'b1;
                    nstate  = DRIVE;
                end else if (!empty) begin
                    pop    = 1'b1;
                    nstate = DRIVE;
                end else begin
                    nstate = IDLE;
                end
            end
            default: nstate = IDLE;
        endcase
        nxt_op = pop ? head[1:0] : op_r;
    end

    // Command latch, counters, expected state, sticky error, j/k pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_r  <= OP_HOLD;
            rem_r <= '0;
            wcnt  <= '0;
            exp_r <= 1'b0;
            err   <= 1'b0;
            j     <= 1'b0;
            k     <= 1'b0;
        end else begin
            if (pop) begin
                op_r  <= op_e'(head[1:0]);
                rem_r <= head[CNT_W+1:2];
            end else if (dec_rem) begin
                rem_r <= rem_r - 1'b1;
            end
            if (state == DRIVE) begin
                wcnt  <= WW'(FB_LAT - 1);
                exp_r <= next_exp(op_r, exp_r);
            end else if (state == WAIT && wcnt != '0) begin
                wcnt <= wcnt - 1'b1;
            end
            err <= mismatch || (err && !err_clr);
            j   <= (nstate == DRIVE) && nxt_op[0];
            k   <= (nstate == DRIVE) && nxt_op[1];
        end
    end

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Bench for jk_cmd_sequencer: directed scenarios plus random traffic.
// A queue/timeline reference model predicts every output each cycle.
module tb_jk_cmd_sequencer;

    localparam int DEPTH  = 4;
    localparam int CNT_W  = 4;
    localparam int FB_LAT = 2;
    localparam int PER    = FB_LAT + 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_rep;
    logic       j;
    logic       k;
    logic       q_fb;
    logic       err_clr;
    logic       err;
    logic       busy;
    logic [2:0] level;
    logic       jkq;
    logic       force0;

    int total = 0;
    int bad   = 0;

    int q_op[$];
    int q_rep[$];
    bit act;
    int left;
    int cur_op;
    bit exp_m;
    bit err_m;

    always #5 clk = ~clk;

    // Behavioural JK flip-flop closing the feedback loop.
    always @(posedge clk or posedge rst) begin
        if (rst)         jkq <= 1'b0;
        else if (j && k) jkq <= ~jkq;
        else if (j)      jkq <= 1'b1;
        else if (k)      jkq <= 1'b0;
    end

    assign q_fb = force0 ? 1'b0 : jkq;

    jk_cmd_sequencer #(
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W),
        .FB_LAT (FB_LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_rep   (cmd_rep),
        .j         (j),
        .k         (k),
        .q_fb      (q_fb),
        .err_clr   (err_clr),
        .err       (err),
        .busy      (busy),
        .level     (level)
    );

    function automatic bit nexp(input int op, input bit e);
        case (op)
            1:       return 1'b1;
            2:       return 1'b0;
            3:       return ~e;
            default: return e;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag);
        bit drv;
        drv = act && (left % PER == 0);
        chk({tag, ".j"}, 8'(j), 8'(drv && cur_op[0]));
        chk({tag, ".k"}, 8'(k), 8'(drv && cur_op[1]));
        chk({tag, ".level"}, 8'(level), 8'(q_op.size()));
        chk({tag, ".ready"}, 8'(cmd_ready), 8'(q_op.size() < DEPTH));
        chk({tag, ".busy"}, 8'(busy), 8'(act || q_op.size() > 0));
        chk({tag, ".err"}, 8'(err), 8'(err_m));
    endtask

    task automatic model_reset();
        q_op.delete();
        q_rep.delete();
        act   = 1'b0;
        left  = 0;
        cur_op = 0;
        exp_m = 1'b0;
        err_m = 1'b0;
    endtask

    task automatic step(input string tag, input bit v, input int op,
                        input int rep, input bit clr, input bit f);
        bit qs;
        bit acc;
        bit in_chk;
        bit in_drv;
        @(negedge clk);
        cmd_valid = v;
        cmd_op    = op[1:0];
        cmd_rep   = rep[3:0];
        err_clr   = clr;
        force0    = f;
        #1;
        qs     = q_fb;
        acc    = v && (q_op.size() < DEPTH);
        in_chk = act && (left % PER == 1);
        in_drv = act && (left % PER == 0);
        @(posedge clk);
        #1;
        if (in_chk && qs != exp_m) err_m = 1'b1;
        else if (clr)              err_m = 1'b0;
        if (in_drv) exp_m = nexp(cur_op, exp_m);
        if (act) begin
            left--;
            if (left == 0) act = 1'b0;
        end
        if (!act && q_op.size() > 0) begin
            cur_op = q_op.pop_front();
            left   = (q_rep.pop_front() + 1) * PER;
            act    = 1'b1;
        end
        if (acc) begin
            q_op.push_back(op & 3);
            q_rep.push_back(rep & 15);
        end
        check_all(tag);
    endtask

    task automatic idle(input string tag, input int n, input bit f);
        for (int i = 0; i < n; i++) step(tag, 1'b0, 0, 0, 1'b0, f);
    endtask

    task automatic drain(input string tag, input bit clr, input bit f);
        for (int i = 0; i < 400 && (act || q_op.size() > 0); i++)
            step(tag, 1'b0, 0, 0, clr, f);
    endtask

    // Mid-cycle asynchronous reset; outputs must clear immediately.
    task automatic do_reset(input string tag);
        #3;
        cmd_valid = 1'b0;
        err_clr   = 1'b0;
        force0    = 1'b0;
        rst       = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_rep   = 4'd0;
        err_clr   = 1'b0;
        force0    = 1'b0;
        model_reset();
        #2;
        check_all("por");
        @(negedge clk);
        rst = 1'b0;

        step("set0", 1'b1, 1, 0, 1'b0, 1'b0);
        idle("set0", 6, 1'b0);

        do_reset("rst_tog");
        step("tog2", 1'b1, 3, 2, 1'b0, 1'b0);
        idle("tog2", 14, 1'b0);

        for (int i = 0; i < 6; i++) step("fill", 1'b1, 3, 3, 1'b0, 1'b0);
        drain("fill", 1'b0, 1'b0);

        step("err", 1'b1, 1, 0, 1'b0, 1'b1);
        drain("err", 1'b0, 1'b1);
        step("errclr", 1'b0, 0, 0, 1'b1, 1'b1);
        step("errset", 1'b1, 1, 0, 1'b0, 1'b1);
        drain("errset", 1'b1, 1'b1);
        idle("errhold", 2, 1'b0);
        step("errclr2", 1'b0, 0, 0, 1'b1, 1'b0);

        step("mid", 1'b1, 2, 1, 1'b0, 1'b0);
        step("mid", 1'b1, 1, 0, 1'b0, 1'b0);
        step("mid", 1'b1, 3, 2, 1'b0, 1'b0);
        for (int i = 0; i < 20 && !(act && left % PER == 3); i++)
            step("mid", 1'b0, 0, 0, 1'b0, 1'b0);
        chk("mid.inwait", 8'(act && left % PER == 3), 8'd1);
        do_reset("rst_mid");
        idle("after_rst", 20, 1'b0);

        for (int i = 0; i < 600; i++) begin
            step("rand",
                 ($urandom_range(0, 2) != 0),
                 int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 2)),
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 15) == 0));
        end
        drain("rand_drain", 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
